// File: rtl/m_div_pkg.sv
// Shared types for the sequential M-extension divider: operation codes,
// FSM states, datapath register select codes and op-decoding helpers.
package m_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    typedef enum logic [2:0] {
        SEL_KEEP,
        SEL_LOAD,
        SEL_LOAD_NEG,
        SEL_SUB_KEEP,
        SEL_SHR,
        SEL_SHL_ADD
    } reg_sel_e;

    function automatic logic is_signed(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_quot(input div_op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/m_div_regs.sv
// Restoring-division datapath: partial remainder R, shifted divisor D and
// quotient Z, each steered by a select code from the controlling FSM.
module m_div_regs
    import m_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  reg_sel_e         r_sel,
    input  reg_sel_e         d_sel,
    input  reg_sel_e         z_sel,
    input  logic [WIDTH-1:0] load_r,
    input  logic [WIDTH-1:0] load_d,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] z_out,
    output logic             sub_neg
);

    logic [WIDTH-1:0]   r_q, r_d;
    logic [2*WIDTH-2:0] d_q, d_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic [2*WIDTH-1:0] diff;
    logic [WIDTH-1:0]   neg_load_r;
    logic [WIDTH-1:0]   neg_load_d;

    // Trial subtraction; the top bit is the borrow that decides the quotient bit.
    assign diff       = {{WIDTH{1'b0}}, r_q} - {1'b0, d_q};
    assign sub_neg    = diff[2*WIDTH-1];
    assign neg_load_r = -load_r;
    assign neg_load_d = -load_d;
    assign r_out      = r_q;
    assign z_out      = z_q;

    always_comb begin
        r_d = r_q;
        d_d = d_q;
        z_d = z_q;

        case (r_sel)
            SEL_LOAD:     r_d = load_r;
            SEL_LOAD_NEG: r_d = neg_load_r;
            SEL_SUB_KEEP: if (!sub_neg) r_d = diff[WIDTH-1:0];
            default:      r_d = r_q;
        endcase

        case (d_sel)
            SEL_LOAD:     d_d = {load_d, {(WIDTH-1){1'b0}}};
            SEL_LOAD_NEG: d_d = {neg_load_d, {(WIDTH-1){1'b0}}};
            SEL_SHR:      d_d = d_q >> 1;
            default:      d_d = d_q;
        endcase

        case (z_sel)
            SEL_LOAD:    z_d = '0;
            SEL_SHL_ADD: z_d = {z_q[WIDTH-2:0], ~sub_neg};
            default:     z_d = z_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
            d_q <= '0;
            z_q <= '0;
        end else begin
            r_q <= r_d;
            d_q <= d_d;
            z_q <= z_d;
        end
    end

endmodule

// File: rtl/m_div_seq.sv
// Sequential DIV/DIVU/REM/REMU unit: one restoring step per cycle, sign
// fix-up at the end, and single-cycle shortcuts for div-by-zero and overflow.
module m_div_seq
    import m_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  div_op_e          op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    div_op_e          op_q, op_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    reg_sel_e         r_sel, d_sel, z_sel;
    logic [WIDTH-1:0] r_val, z_val;
    logic [WIDTH-1:0] quot_val, rem_val;
    logic             sub_neg;
    logic             accept;
    logic             a_neg, b_neg;

    m_div_regs #(.WIDTH(WIDTH)) u_regs (
        .clk     (clk),
        .reset   (reset),
        .r_sel   (r_sel),
        .d_sel   (d_sel),
        .z_sel   (z_sel),
        .load_r  (rs1),
        .load_d  (rs2),
        .r_out   (r_val),
        .z_out   (z_val),
        .sub_neg (sub_neg)
    );

    assign in_ready  = (state_q == IDLE) && !flush;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign accept    = in_valid && in_ready;
    assign a_neg     = is_signed(op) && rs1[WIDTH-1];
    assign b_neg     = is_signed(op) && rs2[WIDTH-1];
    assign quot_val  = (neg_a_q ^ neg_b_q) ? -z_val : z_val;
    assign rem_val   = neg_a_q ? -r_val : r_val;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        r_sel    = SEL_KEEP;
        d_sel    = SEL_KEEP;
        z_sel    = SEL_KEEP;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op;
                    neg_a_d = a_neg;
                    neg_b_d = b_neg;
                    r_sel   = a_neg ? SEL_LOAD_NEG : SEL_LOAD;
                    d_sel   = b_neg ? SEL_LOAD_NEG : SEL_LOAD;
                    z_sel   = SEL_LOAD;
                    cnt_d   = CNT_W'(WIDTH);
                    if (rs2 == '0) begin
                        result_d = is_quot(op) ? '1 : rs1;
                        state_d  = DONE;
                    end else if (is_signed(op) && (rs1 == MIN_VAL) && (rs2 == '1)) begin
                        result_d = is_quot(op) ? MIN_VAL : '0;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_sel = SEL_SUB_KEEP;
                d_sel = SEL_SHR;
                z_sel = SEL_SHL_ADD;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
            FIX: begin
                result_d = is_quot(op_q) ? quot_val : rem_val;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything else and discards any result being formed.
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= DIV;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_m_div_seq.sv
// Self-checking bench for m_div_seq at WIDTH=32 and WIDTH=8: directed corner
// cases plus randomized operations compared against an arithmetic model.
module tb_m_div_seq;
    import m_div_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        out_ready;
    div_op_e     op;
    logic [31:0] rs1, rs2;

    logic        in_valid_w, in_ready_w, out_valid_w, busy_w;
    logic [31:0] result_w;
    logic        in_valid_n, in_ready_n, out_valid_n, busy_n;
    logic [7:0]  result_n;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    m_div_seq #(.WIDTH(32)) u_dut_w (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid_w),
        .in_ready  (in_ready_w),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .result    (result_w),
        .busy      (busy_w)
    );

    m_div_seq #(.WIDTH(8)) u_dut_n (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid_n),
        .in_ready  (in_ready_n),
        .op        (op),
        .rs1       (rs1[7:0]),
        .rs2       (rs2[7:0]),
        .out_valid (out_valid_n),
        .out_ready (out_ready),
        .result    (result_n),
        .busy      (busy_n)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Division semantics computed directly from the RISC-V rules on wide integers.
    function automatic logic [31:0] refModel(input int w, input div_op_e o, input logic [31:0] a, input logic [31:0] b);
        longint mask, ua, ub, sa, sb, minv, q;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        minv = -(longint'(1) << (w - 1));
        case (o)
            DIVU:    q = (ub == 0) ? mask : ua / ub;
            REMU:    q = (ub == 0) ? ua : ua % ub;
            DIV:     q = (ub == 0) ? mask : ((sa == minv && sb == -1) ? minv : sa / sb);
            REM:     q = (ub == 0) ? ua : ((sa == minv && sb == -1) ? 0 : sa % sb);
            default: q = 0;
        endcase
        return 32'(q & mask);
    endfunction

    function automatic logic ovOf(input bit narrow);
        return narrow ? out_valid_n : out_valid_w;
    endfunction

    function automatic logic busyOf(input bit narrow);
        return narrow ? busy_n : busy_w;
    endfunction

    function automatic logic [31:0] resOf(input bit narrow);
        return narrow ? {24'd0, result_n} : result_w;
    endfunction

    task automatic startOp(input bit narrow, input div_op_e o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op  = o;
        rs1 = a;
        rs2 = b;
        if (narrow) in_valid_n = 1'b1;
        else        in_valid_w = 1'b1;
        @(posedge clk);
        #1;
        in_valid_n = 1'b0;
        in_valid_w = 1'b0;
    endtask

    // Latency counts rising edges from the accepting edge up to the first edge
    // after which out_valid is seen.
    task automatic waitResult(input bit narrow, output logic [31:0] res, output int lat, output bit busy_ok);
        lat     = 1;
        busy_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (ovOf(narrow)) break;
            if (!busyOf(narrow)) busy_ok = 1'b0;
            if (lat >= 200) begin
                checkOutput("result_timeout", 32'(lat), 32'd0);
                break;
            end
            @(posedge clk);
            lat++;
        end
        res = resOf(narrow);
    endtask

    task automatic releaseResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic applyStimulus(input bit narrow, input div_op_e o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output int lat, output bit busy_ok);
        startOp(narrow, o, a, b);
        waitResult(narrow, res, lat, busy_ok);
        releaseResult();
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        bit          bz;
        bit          seen_valid;
        bit          narrow;
        div_op_e     o;
        logic [31:0] a, b;

        reset      = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        in_valid_w = 1'b0;
        in_valid_n = 1'b0;
        op         = DIV;
        rs1        = '0;
        rs2        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready_w), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid_w), 32'd0);
        checkOutput("reset_busy", 32'(busy_w), 32'd0);
        checkOutput("reset_result", result_w, 32'd0);
        checkOutput("reset_in_ready_n", 32'(in_ready_n), 32'd1);
        reset = 1'b0;

        applyStimulus(0, DIVU, 32'd789, 32'd7, res, lat, bz);
        checkOutput("divu_789_7", res, 32'd112);
        checkOutput("divu_latency", 32'(lat), 32'd34);
        checkOutput("divu_busy", 32'(bz), 32'd1);
        applyStimulus(0, REMU, 32'd789, 32'd7, res, lat, bz);
        checkOutput("remu_789_7", res, 32'd5);
        applyStimulus(0, DIV, 32'(-7890), 32'd123, res, lat, bz);
        checkOutput("div_neg7890_123", res, 32'hFFFF_FFC0);
        applyStimulus(0, REM, 32'(-7890), 32'd123, res, lat, bz);
        checkOutput("rem_neg7890_123", res, 32'hFFFF_FFEE);
        applyStimulus(0, REM, 32'd7890, 32'(-123), res, lat, bz);
        checkOutput("rem_7890_neg123", res, 32'd18);
        applyStimulus(0, DIV, 32'h1234_5678, 32'd0, res, lat, bz);
        checkOutput("div_by_zero", res, 32'hFFFF_FFFF);
        checkOutput("div_by_zero_latency", 32'(lat), 32'd1);
        applyStimulus(0, REM, 32'd789, 32'd0, res, lat, bz);
        checkOutput("rem_by_zero", res, 32'd789);
        applyStimulus(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bz);
        checkOutput("div_overflow", res, 32'h8000_0000);
        checkOutput("div_overflow_latency", 32'(lat), 32'd1);
        applyStimulus(0, REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bz);
        checkOutput("rem_overflow", res, 32'd0);
        applyStimulus(0, DIV, 32'h8000_0000, 32'd2, res, lat, bz);
        checkOutput("div_min_by_2", res, 32'hC000_0000);

        // Consumer stalls for five cycles in DONE.
        startOp(0, DIVU, 32'd1000, 32'd3);
        waitResult(0, res, lat, bz);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("hold_out_valid", 32'(out_valid_w), 32'd1);
        checkOutput("hold_result", result_w, 32'd333);
        checkOutput("hold_in_ready", 32'(in_ready_w), 32'd0);
        releaseResult();
        @(negedge clk);
        checkOutput("release_in_ready", 32'(in_ready_w), 32'd1);
        checkOutput("release_busy", 32'(busy_w), 32'd0);

        // Flush in the middle of the iteration loop.
        startOp(0, DIVU, 32'hFFFF_FFFF, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy", 32'(busy_w), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready_w), 32'd1);
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_w) seen_valid = 1'b1;
        end
        checkOutput("flush_no_out_valid", 32'(seen_valid), 32'd0);
        applyStimulus(0, DIVU, 32'd100, 32'd9, res, lat, bz);
        checkOutput("after_flush_divu", res, 32'd11);

        // Flush must block an accept offered in the same cycle.
        @(negedge clk);
        flush      = 1'b1;
        in_valid_w = 1'b1;
        op         = DIVU;
        rs1        = 32'd50;
        rs2        = 32'd5;
        #1;
        checkOutput("flush_blocks_ready", 32'(in_ready_w), 32'd0);
        @(posedge clk);
        #1;
        flush      = 1'b0;
        in_valid_w = 1'b0;
        @(negedge clk);
        checkOutput("flush_blocks_accept", 32'(busy_w), 32'd0);

        // Reset partway through an operation.
        startOp(0, DIV, 32'd123456, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_busy", 32'(busy_w), 32'd0);
        checkOutput("midreset_out_valid", 32'(out_valid_w), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready_w), 32'd1);
        checkOutput("midreset_result", result_w, 32'd0);
        reset = 1'b0;

        applyStimulus(1, DIV, 32'h80, 32'hFF, res, lat, bz);
        checkOutput("w8_div_overflow", res, 32'h80);
        applyStimulus(1, DIVU, 32'd200, 32'd3, res, lat, bz);
        checkOutput("w8_divu_200_3", res, 32'd66);
        checkOutput("w8_divu_latency", 32'(lat), 32'd10);

        for (int i = 0; i < 300; i++) begin
            narrow = (i % 2) == 1;
            o      = div_op_e'($urandom_range(0, 3));
            a      = $urandom;
            b      = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin
                    a = narrow ? 32'h80 : 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                2: b = $urandom_range(1, 15);
                3: b = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: ;
            endcase
            applyStimulus(narrow, o, a, b, res, lat, bz);
            checkOutput($sformatf("rand%0d_w%0d_op%0d", i, narrow ? 8 : 32, int'(o)), res,
                        refModel(narrow ? 8 : 32, o, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
